// File: rtl/fft_run_ctrl.sv
// Run controller for the fft8/fft16/fft32 engines: accepts one sized request,
// launches and enables exactly one engine, waits for done with a timeout, holds the result.
module fft_run_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_size_i,
  output logic [2:0]       start_o,
  output logic [2:0]       en_o,
  input  logic [2:0]       done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_size_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int unsigned       TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [TMR_W-1:0] r_timer;
  logic             r_req_ready;
  logic [2:0]       r_start;
  logic [2:0]       r_en;
  logic             r_out_valid;
  logic [1:0]       r_out_size;
  logic             r_busy;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_frame_cnt;

  logic [1:0] w_state_nx;
  logic [1:0] w_sel_nx;
  logic [2:0] w_sel_oh;
  logic [2:0] w_sel_nx_oh;
  logic       w_accept;
  logic       w_legal;
  logic       w_illegal_req;
  logic       w_done_sel;
  logic       w_timeout;
  logic       w_handshake;

  function automatic logic [2:0] size_onehot(input logic [1:0] s);
    case (s)
      2'd0:    size_onehot = 3'b001;
      2'd1:    size_onehot = 3'b010;
      2'd2:    size_onehot = 3'b100;
      default: size_onehot = 3'b000;
    endcase
  endfunction

  // Requests are only taken while req_ready_o is actually advertised.
  always_comb begin
    w_accept      = (r_state == S_IDLE) && r_req_ready && req_valid_i;
    w_legal       = (req_size_i != 2'd3);
    w_illegal_req = w_accept && !w_legal;
    w_sel_oh      = size_onehot(r_sel);
    w_done_sel    = |(done_i & w_sel_oh);
    w_timeout     = (r_state == S_BUSY) && !w_done_sel && (r_timer == TMR_LAST);
    w_handshake   = (r_state == S_HOLD) && out_ready_i;
    w_sel_nx      = (w_accept && w_legal) ? req_size_i : r_sel;
    w_sel_nx_oh   = size_onehot(w_sel_nx);
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_legal) w_state_nx = S_LAUNCH;
      S_LAUNCH: w_state_nx = S_BUSY;
      S_BUSY: begin
        if (w_done_sel)     w_state_nx = S_HOLD;
        else if (w_timeout) w_state_nx = S_IDLE;
      end
      S_HOLD:   if (out_ready_i) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state so they line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_timer     <= '0;
      r_req_ready <= 1'b0;
      r_start     <= '0;
      r_en        <= '0;
      r_out_valid <= 1'b0;
      r_out_size  <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_sel       <= w_sel_nx;
      if (r_state == S_LAUNCH)    r_timer <= '0;
      else if (r_state == S_BUSY) r_timer <= r_timer + TMR_W'(1);
      r_req_ready <= (w_state_nx == S_IDLE);
      r_start     <= (w_state_nx == S_LAUNCH) ? w_sel_nx_oh : 3'b000;
      r_en        <= (w_state_nx != S_IDLE) ? w_sel_nx_oh : 3'b000;
      r_out_valid <= (w_state_nx == S_HOLD);
      r_busy      <= (w_state_nx != S_IDLE);
      if (w_accept && w_legal) r_out_size <= req_size_i;
      r_err       <= w_illegal_req || w_timeout;
      if (w_illegal_req)  r_err_code <= 2'd1;
      else if (w_timeout) r_err_code <= 2'd2;
      if (w_handshake) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign req_ready_o = r_req_ready;
  assign start_o     = r_start;
  assign en_o        = r_en;
  assign out_valid_o = r_out_valid;
  assign out_size_o  = r_out_size;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: doc/fft_run_ctrl.md
# fft_run_ctrl

Run controller for the radix-2 FFT subsystem. It accepts one transform request at a time, selecting an 8-, 16- or 32-point size. It starts and enables exactly one FFT engine, so the OR-based output mux only ever sees one non-zero engine. It then waits for that engine's completion, with a timeout, and holds the result valid until the downstream consumer takes it. It sits between the request source and the fft8/fft16/fft32 engines plus output mux.

## Interface

Parameters:

- TIMEOUT, 64: maximum BUSY cycles allowed before a run aborts; must be at least 2.
- CNT_W, 16: width of the completed-frame counter.

Ports:

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller can accept a request.
- req_size_i  in  2  requested size: 0=8-pt, 1=16-pt, 2=32-pt, 3=illegal.
- start_o  out  3  one-cycle start pulse, one-hot; bit0=fft8, bit1=fft16, bit2=fft32.
- en_o  out  3  engine output enable, one-hot or zero. A disabled engine drives zeros into the mux.
- done_i  in  3  per-engine completion pulses, same bit order.
- out_valid_o  out  1  mux output holds a finished transform.
- out_ready_i  in  1  consumer takes the result.
- out_size_o  out  2  size code of the run currently enabled.
- busy_o  out  1  high in LAUNCH, BUSY and HOLD.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  0=none, 1=illegal size, 2=timeout. Held until the next error or reset.
- frame_cnt_o  out  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

## Operation

- Outputs are registered. States are IDLE, LAUNCH, BUSY and HOLD.
- Reset values: state IDLE; req_ready_o=0; start_o, en_o, out_size_o, err_code_o and frame_cnt_o all 0; out_valid_o, busy_o and err_o 0. req_ready_o rises on the first clock edge after rst_i deasserts.
- **IDLE**: req_ready_o=1.
  - On req_valid_i with size 0..2: latch the size and go to LAUNCH.
  - On req_valid_i with size 3: the request is consumed, err_o pulses, err_code_o becomes 1, and the state stays IDLE.
- **LAUNCH** (exactly one cycle):
  - start_o[sel]=1 and en_o[sel]=1; out_size_o = latched size.
  - Timer clears to 0; next state is BUSY.
- **BUSY**:
  - en_o[sel] is held. The timer increments every cycle starting from 0.
  - done_i[sel] high: go to HOLD.
  - done_i bits for unselected engines are ignored. done_i is ignored outside BUSY.
  - Timer equals TIMEOUT-1 with no done_i[sel]: err_o pulses, err_code_o becomes 2, en_o clears, return to IDLE.
  - done_i[sel] arriving on the timeout cycle: completion wins and no error is raised.
- **HOLD**:
  - out_valid_o=1 and en_o[sel] is held, so the mux output stays stable.
  - On out_ready_i: frame_cnt_o increments, and the next cycle is IDLE with en_o=0, out_valid_o=0 and req_ready_o=1.
  - out_valid_o never drops without a handshake.
- en_o never has more than one bit set. start_o is high only in LAUNCH.
- rst_i asserted mid-run forces every output to its reset value immediately, asynchronously. No error is reported.

## Timing

- Request handshake at edge T: LAUNCH during cycle T+1 (start_o high), BUSY from T+2.
- done_i[sel] sampled high at edge D: out_valid_o high from D+1.
- Output handshake at edge H: IDLE from H+1, so the next request can be accepted at edge H+1.
- Minimum request-to-request period is 4 cycles (IDLE, LAUNCH, BUSY, HOLD), with zero-latency done and ready.
- Timeout: err_o is high in the cycle after the TIMEOUT-th BUSY cycle, together with req_ready_o=1.
- Illegal-size err_o is high in the cycle after the request edge. The controller accepts again in that same cycle.

## Test plan

- **Reset release:** check every output is at its reset value while rst_i=1, and that req_ready_o=1 one edge after release.
- **Normal 16-pt run:** request size=1 and return done_i=3'b010 five cycles after start.
  - Expect start_o=3'b010 for exactly 1 cycle and en_o=3'b010 from LAUNCH through HOLD.
  - Expect out_valid_o the cycle after done and out_size_o=1.
  - With out_ready_i held 3 cycles late, expect out_valid_o held, then frame_cnt_o=1.
- **Wrong-engine done:** request size=2, pulse done_i=3'b001, then 3'b100 two cycles later. Expect HOLD entered only after the 3'b100 pulse.
- **Timeout:** with TIMEOUT=8, request size=0 and never assert done.
  - Expect err_o pulse, err_code_o=2 and en_o=0 after 8 BUSY cycles, with req_ready_o=1.
  - Repeat with done_i[0] on timer=7: expect HOLD and no error.
- **Illegal size:** request size=3. Expect err_o pulse, err_code_o=1, start_o stays 0, and a legal request is accepted on the next cycle.
- **Back-to-back and async reset:** issue three consecutive 8-pt runs with immediate done and ready; expect a 4-cycle period and frame_cnt_o=3.
  - Then assert rst_i during BUSY: expect en_o=0, busy_o=0 and frame_cnt_o=0 without waiting for a clock edge.
